// File: rtl/nv_ram_rws_param_if.sv
// Port bundle for nv_ram_rws_param: read port, write port, status flags and the
// FSM debug view. The master drives addresses/data, the slave is the RAM.
//
// Handshake: there is no ready back-pressure. A read (re=1) or a write (we=1)
// presented on a rising edge is accepted exactly when init_busy was low before
// that edge; while init_busy is high every port access is silently dropped.
// An accepted read returns one dout_vld pulse after the read latency.
interface nv_ram_rws_param_if #(
    parameter int AW = 8,
    parameter int DW = 64,
    parameter int MW = 8
);
    logic [AW-1:0] ra;
    logic          re;
    logic [DW-1:0] dout;
    logic          dout_vld;
    logic [AW-1:0] wa;
    logic          we;
    logic [MW-1:0] wmask;
    logic [DW-1:0] di;
    logic          init_busy;
    logic          collision;
    logic [31:0]   pwrbus_ram_pd;
    // Debug view of the sequencer: 0 = INIT (clearing), 1 = READY.
    logic          fsm_state;

    modport master (
        output ra, re, wa, we, wmask, di, pwrbus_ram_pd,
        input  dout, dout_vld, init_busy, collision, fsm_state
    );

    modport slave (
        input  ra, re, wa, we, wmask, di, pwrbus_ram_pd,
        output dout, dout_vld, init_busy, collision, fsm_state
    );
endinterface

// File: rtl/nv_ram_rws_param.sv
// Parametrised one-read/one-write synchronous RAM with per-lane write mask,
// write-first bypass on address collision, optional output register and a
// reset-triggered sequencer that zero-fills the array before accepting traffic.
module nv_ram_rws_param #(
    parameter int   DW      = 64,
    parameter int   DEPTH   = 256,
    parameter int   AW      = 8,
    parameter int   MG      = 8,
    parameter int   OUT_REG = 0,
    parameter logic FORCE_CONTENTION_ASSERTION_RESET_ACTIVE = 1'b0
) (
    input  logic                clk,
    input  logic                rst,
    nv_ram_rws_param_if.slave   bus
);
    localparam int MW = DW / MG;
    // Index width sized to the array itself; DEPTH <= 2^AW keeps it <= AW.
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic {
        ST_INIT  = 1'b0,
        ST_READY = 1'b1
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [IW-1:0] clr_cnt;
    logic          ready;

    logic [DW-1:0] mem [DEPTH];

    logic          ra_ok;
    logic          wa_ok;
    logic [IW-1:0] rd_idx;
    logic [IW-1:0] wr_idx;
    logic          rd_go;
    logic          wr_go;
    logic          addr_hit;
    logic [DW-1:0] rd_word;

    logic [DW-1:0] rd_q;
    logic          vld_q;
    logic          coll_q;

    // Sequencer state register: reset always restarts the clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_INIT;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state: leave INIT after the last word has been cleared.
    always_comb begin
        state_nxt = state;
        if (state == ST_INIT && clr_cnt == IW'(DEPTH - 1)) begin
            state_nxt = ST_READY;
        end
    end

    // Sequencer outputs: busy flag and debug view.
    always_comb begin
        ready         = (state == ST_READY);
        bus.init_busy = ~ready;
        bus.fsm_state = state;
    end

    // Clear address counter; parks on the last word once the clear completes.
    always_ff @(posedge clk) begin
        if (rst) begin
            clr_cnt <= '0;
        end else if (!ready && clr_cnt != IW'(DEPTH - 1)) begin
            clr_cnt <= clr_cnt + IW'(1);
        end
    end

    // Out-of-range addresses never touch the array.
    assign ra_ok    = 32'(bus.ra) < DEPTH;
    assign wa_ok    = 32'(bus.wa) < DEPTH;
    assign rd_idx   = bus.ra[IW-1:0];
    assign wr_idx   = bus.wa[IW-1:0];
    assign rd_go    = ready & ~rst & bus.re;
    assign wr_go    = ready & ~rst & bus.we & wa_ok;
    assign addr_hit = bus.we & (bus.ra == bus.wa) & ra_ok;

    // Read word with write-first bypass of the lanes being written this cycle.
    always_comb begin
        rd_word = ra_ok ? mem[rd_idx] : '0;
        for (int i = 0; i < MW; i++) begin
            if (addr_hit && bus.wmask[i]) begin
                rd_word[i*MG +: MG] = bus.di[i*MG +: MG];
            end
        end
    end

    // Array update: zero-fill during INIT, masked port writes in READY.
    always_ff @(posedge clk) begin
        if (!ready) begin
            mem[clr_cnt] <= '0;
        end else if (wr_go) begin
            for (int i = 0; i < MW; i++) begin
                if (bus.wmask[i]) begin
                    mem[wr_idx][i*MG +: MG] <= bus.di[i*MG +: MG];
                end
            end
        end
    end

    // Data register, valid and collision flag; data holds when no read is taken.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_q   <= '0;
            vld_q  <= 1'b0;
            coll_q <= 1'b0;
        end else begin
            vld_q  <= rd_go;
            coll_q <= rd_go & bus.we & (bus.ra == bus.wa);
            if (rd_go) begin
                rd_q <= rd_word;
            end
        end
    end

    generate
        if (OUT_REG != 0) begin : g_oreg
            logic [DW-1:0] dout_q;
            logic          dout_vld_q;

            // Output pipeline stage; advances every cycle.
            always_ff @(posedge clk) begin
                if (rst) begin
                    dout_q     <= '0;
                    dout_vld_q <= 1'b0;
                end else begin
                    dout_q     <= rd_q;
                    dout_vld_q <= vld_q;
                end
            end

            assign bus.dout     = dout_q;
            assign bus.dout_vld = dout_vld_q;
        end else begin : g_noreg
            assign bus.dout     = rd_q;
            assign bus.dout_vld = vld_q;
        end
    endgenerate

    assign bus.collision = coll_q;

    // Power-down bus and the contention-assertion parameter have no function in this model.
    logic unused_ok;
    assign unused_ok = ^{bus.pwrbus_ram_pd, FORCE_CONTENTION_ASSERTION_RESET_ACTIVE};
endmodule

// File: tb/tb_nv_ram_rws_param.sv
// Bench for nv_ram_rws_param: two instances (no output register / output
// register) share one stimulus stream and are checked every cycle against a
// behavioural model of the RAM, plus literal expectations for key scenarios.
module tb_nv_ram_rws_param;
    localparam int DW    = 64;
    localparam int DEPTH = 256;
    localparam int AW    = 8;
    localparam int MG    = 8;
    localparam int MW    = DW / MG;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [AW-1:0] ra;
    logic          re;
    logic [AW-1:0] wa;
    logic          we;
    logic [MW-1:0] wmask;
    logic [DW-1:0] di;
    logic [31:0]   pwr;

    nv_ram_rws_param_if #(.AW(AW), .DW(DW), .MW(MW)) bus0 ();
    nv_ram_rws_param_if #(.AW(AW), .DW(DW), .MW(MW)) bus1 ();

    assign bus0.ra = ra;    assign bus1.ra = ra;
    assign bus0.re = re;    assign bus1.re = re;
    assign bus0.wa = wa;    assign bus1.wa = wa;
    assign bus0.we = we;    assign bus1.we = we;
    assign bus0.wmask = wmask; assign bus1.wmask = wmask;
    assign bus0.di = di;    assign bus1.di = di;
    assign bus0.pwrbus_ram_pd = pwr; assign bus1.pwrbus_ram_pd = pwr;

    nv_ram_rws_param #(.DW(DW), .DEPTH(DEPTH), .AW(AW), .MG(MG), .OUT_REG(0),
                       .FORCE_CONTENTION_ASSERTION_RESET_ACTIVE(1'b0))
        dut0 (.clk(clk), .rst(rst), .bus(bus0));

    nv_ram_rws_param #(.DW(DW), .DEPTH(DEPTH), .AW(AW), .MG(MG), .OUT_REG(1),
                       .FORCE_CONTENTION_ASSERTION_RESET_ACTIVE(1'b0))
        dut1 (.clk(clk), .rst(rst), .bus(bus1));

    // ---------------- counters / check helper ----------------
    int vectors     = 0;
    int miscompares = 0;

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // The RAM is an array of words; after reset nothing is accepted for DEPTH
    // cycles. Each accepted read produces its word once; dout keeps the most
    // recent read result (one cycle later again for the registered instance).
    logic [DW-1:0] m_mem [DEPTH];
    int            m_busy = 0;
    bit            m_on   = 0;
    logic [DW-1:0] last_rd;     // most recent read result (latency 1 view)
    logic [DW-1:0] last_rd_d;   // same, one cycle older (latency 2 view)
    logic          rd_pulse;
    logic          rd_pulse_d;
    logic          e_coll;
    logic [DW-1:0] m_word;
    bit            m_acc;

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
            m_busy     = DEPTH;
            last_rd    = '0;
            last_rd_d  = '0;
            rd_pulse   = 1'b0;
            rd_pulse_d = 1'b0;
            e_coll     = 1'b0;
            m_on       = 1;
        end else if (m_on) begin
            last_rd_d  = last_rd;
            rd_pulse_d = rd_pulse;
            m_acc      = (m_busy == 0);
            if (m_busy > 0) m_busy--;
            rd_pulse = m_acc && re;
            e_coll   = m_acc && re && we && (ra == wa);
            if (m_acc && re) begin
                m_word = (int'(ra) < DEPTH) ? m_mem[ra] : '0;
                if (we && ra == wa && int'(ra) < DEPTH)
                    for (int i = 0; i < MW; i++)
                        if (wmask[i]) m_word[i*MG +: MG] = di[i*MG +: MG];
                last_rd = m_word;
            end
            if (m_acc && we && int'(wa) < DEPTH)
                for (int i = 0; i < MW; i++)
                    if (wmask[i]) m_mem[wa][i*MG +: MG] = di[i*MG +: MG];
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (m_on) begin
            chk("busy0",  bus0.init_busy, m_busy > 0);
            chk("busy1",  bus1.init_busy, m_busy > 0);
            chk("state0", bus0.fsm_state, m_busy == 0);
            chk("vld0",   bus0.dout_vld,  rd_pulse);
            chk("dout0",  bus0.dout,      last_rd);
            chk("coll0",  bus0.collision, e_coll);
            chk("vld1",   bus1.dout_vld,  rd_pulse_d);
            chk("dout1",  bus1.dout,      last_rd_d);
            chk("coll1",  bus1.collision, e_coll);
        end
    end

    // ---------------- scoreboard for streaming ----------------
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] got_q[$];
    bit            stream_on = 0;

    always @(negedge clk) begin
        if (stream_on && bus0.dout_vld) got_q.push_back(bus0.dout);
    end

    // ---------------- driver tasks ----------------
    task automatic drive(input logic r_e, input logic [AW-1:0] r_a,
                         input logic w_e, input logic [AW-1:0] w_a,
                         input logic [MW-1:0] m, input logic [DW-1:0] d);
        re = r_e; ra = r_a; we = w_e; wa = w_a; wmask = m; di = d;
        pwr = $urandom;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, '0, 1'b0, '0, '0, '0);
    endtask

    task automatic drive_rand(input int amax);
        drive(1'($urandom_range(0, 1)), AW'($urandom_range(0, amax)),
              1'($urandom_range(0, 1)), AW'($urandom_range(0, amax)),
              MW'($urandom), {$urandom, $urandom});
    endtask

    task automatic write_word(input logic [AW-1:0] a, input logic [MW-1:0] m, input logic [DW-1:0] d);
        drive(1'b0, '0, 1'b1, a, m, d);
    endtask

    // Read one address and pin both instances and the model to a literal.
    task automatic lit_read(input string nm, input logic [AW-1:0] a, input logic [DW-1:0] v);
        drive(1'b1, a, 1'b0, '0, '0, '0);
        chk({nm, "_model"}, last_rd, v);
        chk({nm, "_d0"}, bus0.dout, v);
        chk({nm, "_v0"}, bus0.dout_vld, 1'b1);
        idle(1);
        chk({nm, "_d1"}, bus1.dout, v);
        chk({nm, "_v1"}, bus1.dout_vld, 1'b1);
        chk({nm, "_hold0"}, bus0.dout, v);
    endtask

    // Pulse reset for one cycle.
    task automatic pulse_rst();
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
    endtask

    // Count init_busy cycles (bounded) while throwing random traffic at the port.
    task automatic count_clear(output int n);
        n = 0;
        for (int c = 0; c < 1000 && bus0.init_busy; c++) begin
            drive_rand(255);
            n++;
        end
    endtask

    int busy_cnt;

    // ---------------- main sequence ----------------
    initial begin
        re = 0; ra = '0; we = 0; wa = '0; wmask = '0; di = '0; pwr = '0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_dout0", bus0.dout, '0);
        chk("rst_busy0", bus0.init_busy, 1'b1);
        rst = 1'b0;

        // Clear: exactly DEPTH busy cycles, port traffic ignored.
        count_clear(busy_cnt);
        chk("clear_len", 64'(busy_cnt), 64'd256);
        lit_read("clr00", 8'h00, 64'h0);
        lit_read("clr7f", 8'h7F, 64'h0);
        lit_read("clrff", 8'hFF, 64'h0);

        // Basic write / read, then hold with re=0.
        write_word(8'h10, 8'hFF, 64'h0123_4567_89AB_CDEF);
        lit_read("basic", 8'h10, 64'h0123_4567_89AB_CDEF);
        idle(3);
        chk("basic_hold", bus1.dout, 64'h0123_4567_89AB_CDEF);

        // Masked write: low four lanes replaced.
        write_word(8'h20, 8'hFF, 64'h1111_1111_1111_1111);
        write_word(8'h20, 8'h0F, 64'hFFFF_FFFF_FFFF_FFFF);
        lit_read("mask", 8'h20, 64'h1111_1111_FFFF_FFFF);

        // Collision: write-first on written lanes, old data elsewhere.
        write_word(8'h30, 8'hFF, 64'hAAAA_AAAA_AAAA_AAAA);
        drive(1'b1, 8'h30, 1'b1, 8'h30, 8'hF0, 64'h5555_5555_5555_5555);
        chk("coll_d0", bus0.dout, 64'h5555_5555_AAAA_AAAA);
        chk("coll_f0", bus0.collision, 1'b1);
        idle(1);
        chk("coll_d1", bus1.dout, 64'h5555_5555_AAAA_AAAA);
        chk("coll_clr", bus0.collision, 1'b0);

        // Random traffic concentrated on a few addresses to provoke collisions.
        for (int i = 0; i < 1500; i++) drive_rand((i % 4 == 0) ? 255 : 7);
        idle(2);

        // Reset mid-read, then reset again at clear cycle 100.
        write_word(8'h40, 8'hFF, 64'hDEAD_BEEF_0BAD_F00D);
        drive(1'b1, 8'h10, 1'b0, '0, '0, '0);
        pulse_rst();
        for (int i = 0; i < 100; i++) drive_rand(255);
        pulse_rst();
        count_clear(busy_cnt);
        chk("reclear_len", 64'(busy_cnt), 64'd256);
        lit_read("reclr10", 8'h10, 64'h0);
        lit_read("reclr40", 8'h40, 64'h0);

        // Streaming: data = address, then back-to-back reads.
        for (int a = 0; a < DEPTH; a++) write_word(AW'(a), 8'hFF, DW'(a));
        stream_on = 1;
        for (int a = 0; a < DEPTH; a++) begin
            exp_q.push_back(DW'(a));
            drive(1'b1, AW'(a), 1'b0, '0, '0, '0);
        end
        idle(3);
        stream_on = 0;
        chk("stream_cnt", 64'(got_q.size()), 64'd256);
        while (exp_q.size() > 0 && got_q.size() > 0)
            chk("stream_data", got_q.pop_front(), exp_q.pop_front());

        idle(2);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Watchdog: the run must end on its own.
    initial begin
        #1000000;
        miscompares++;
        $display("FAIL watchdog: simulation did not complete in time");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/nv_ram_rws_param.md
# nv_ram_rws_param

Parametrised successor of the fixed 256x64 read/write-separate RAM model. It is a one-read-port, one-write-port synchronous RAM with configurable width and depth, a per-lane write mask, an optional output pipeline register, and write-first bypass on read/write address collision. A reset-triggered clear sequencer zero-fills the array. The block sits in the FPGA RAM model library and is the drop-in for NVDLA buffers that need deterministic post-reset contents.

## Interface
- DW, 64, data width in bits; must be a multiple of MG.
- DEPTH, 256, number of words; 2 ≤ DEPTH ≤ 2^AW.
- AW, 8, address width.
- MG, 8, write-mask granularity in bits; MW = DW/MG mask lanes.
- OUT_REG, 0, 1 adds an output pipeline stage.
- FORCE_CONTENTION_ASSERTION_RESET_ACTIVE, 1'b0, kept for compatibility; no functional effect.

- clk  in  1  single clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- ra  in  AW  read address.
- re  in  1  read enable.
- dout  out  DW  read data.
- dout_vld  out  1  dout carries data from a read issued at the read-latency offset.
- wa  in  AW  write address.
- we  in  1  write enable.
- wmask  in  MW  per-lane write enable; lane i covers di[i*MG +: MG].
- di  in  DW  write data.
- init_busy  out  1  clear sequence in progress; port accesses are ignored.
- collision  out  1  registered flag: the previous accepted cycle had re, we, and ra==wa.
- pwrbus_ram_pd  in  32  power-down bus; ignored in this model.

## Operation
- FSM states are INIT and READY.
  - rst forces INIT, clears clr_cnt to 0, and sets init_busy=1.
  - In INIT, each cycle writes 0 to M[clr_cnt] and increments clr_cnt. When clr_cnt==DEPTH-1, the FSM moves to READY next cycle.
  - READY is held until rst.
- In INIT, re and we are ignored: no array write from the ports, dout_vld=0, collision=0.
- Write in READY: if we, then for each lane i with wmask[i]=1, M[wa] lane i <= di lane i. Masked-off lanes keep their old value.
- Read in READY: if re, the data register captures M[ra].
  - If re=0, the data register holds its value.
  - Later writes to that address do not change dout.
- Collision (re & we & ra==wa): write-first behaviour. The captured word is di on lanes with wmask=1 and old M[ra] on the other lanes. collision is set for one cycle.
- Addresses ≥ DEPTH: writes are dropped, reads return 0. This is not flagged.
- When OUT_REG=1, a second register follows the data register and dout_vld is delayed to match. That stage advances every cycle.

## Timing
- Reset values: dout=0, dout_vld=0, collision=0, init_busy=1, clr_cnt=0, state=INIT.
- Clear duration: init_busy stays high for exactly DEPTH cycles after the first cycle with rst=0. The first accepted access is in cycle DEPTH.
- Read latency is 1 cycle (OUT_REG=0) or 2 cycles (OUT_REG=1) from the re edge to dout/dout_vld.
- dout_vld is high for exactly one cycle per accepted read. Back-to-back reads give one result per cycle.
- A write is visible to a non-colliding read issued on the next cycle.
- If rst is asserted mid-clear or mid-read, the FSM restarts at clr_cnt=0 and in-flight dout_vld is dropped.
  - dout returns to 0 only through rst.
  - Array contents are re-cleared.

## Test plan
- Reset/clear (DEPTH=256): pulse rst for 1 cycle -> init_busy high for 256 cycles. Reads of 0x00, 0x7F and 0xFF then return 0. re/we issued during clear have no effect.
- Basic read/write: write 0x0123456789ABCDEF to address 0x10 with wmask=0xFF, then re at 0x10 -> dout=0x0123456789ABCDEF with dout_vld one cycle later (two cycles with OUT_REG=1). dout holds with re=0.
- Masked write: word 0x1111111111111111 at 0x20, then write 0xFFFFFFFFFFFFFFFF with wmask=0x0F -> read gives 0x11111111FFFFFFFF.
- Collision: M[0x30]=0xAAAAAAAAAAAAAAAA. In the same cycle, re/we at 0x30 with di=0x5555555555555555 and wmask=0xF0 -> dout=0x55555555AAAAAAAA and collision=1 for one cycle.
- Reset mid-clear: assert rst at clear cycle 100 -> init_busy stays high for 256 further cycles, and previously written data reads back 0.
- Streaming: 256 back-to-back reads following 256 writes of data=address -> dout sequence 0..255 with dout_vld continuously high.
